systolic_data_setup: RTL and testbench
======================================

Name: systolic_data_setup

Overview:
- Upstream feeder for the square systolic matrix-multiply array (LENGTH x LENGTH output-stationary PEs).
- Accepts one input vector and one weight vector per handshake and diagonally skews both, so lane i reaches the array i steps late.
- Generates the array's clear and enable strobes, then drains the pipeline with zero vectors and signals frame completion.

Parameters:
- WIDTH, 8: element width in bits, matching the array's WIDTH.
- LENGTH, 256: array dimension; number of lanes in each vector.

Ports:
- CLK  in  1  clock; all logic rising-edge.
- SYNC_RST  in  1  synchronous, active-low reset.
- START  in  1  begins a frame; sampled only in IDLE.
- IN_VALID  in  1  upstream vector pair valid.
- IN_READY  out  1  block accepts a vector pair this cycle.
- IN_LAST  in  1  qualifies the final pair of a frame; sampled on accept.
- IN_INPUTS  in  WIDTH x LENGTH  row-side input vector, unpacked [0:LENGTH-1].
- IN_WEIGHTS  in  WIDTH x LENGTH  column-side weight vector, unpacked [0:LENGTH-1].
- ARR_INPUTS  out  WIDTH x LENGTH  skewed inputs to the array's Inputs.
- ARR_WEIGHTS  out  WIDTH x LENGTH  skewed weights to the array's Weights.
- ARR_EN  out  1  array enable; one cycle per step.
- ARR_CLR  out  1  array accumulator clear pulse, driving the array's SYNC_RST.
- BUSY  out  1  high in any state other than IDLE.
- DONE  out  1  one-cycle pulse when the frame has fully drained.

Behaviour:
- Reset (SYNC_RST=0 at an edge): state=IDLE; all skew registers=0; ARR_INPUTS/ARR_WEIGHTS=0; ARR_EN=0; ARR_CLR=0; DONE=0; drain counter=0.
  - Reset mid-frame aborts the frame. DONE is not issued.
- States: IDLE, CLEAR, STREAM, DRAIN.
  - IDLE: IN_READY=0. START=1 -> CLEAR.
  - CLEAR: lasts one cycle. ARR_CLR=1 (registered, so visible during this cycle); IN_READY=0. -> STREAM.
  - STREAM: IN_READY=1. An accept (IN_VALID & IN_READY) is a step that shifts in the input pair.
    - Accept with IN_LAST=1 -> DRAIN, with drain counter loaded to 2*(LENGTH-1).
  - DRAIN: IN_READY=0. While the counter is nonzero, each cycle is a step that shifts in zero vectors, and the counter decrements.
    - When the counter is 0 -> IDLE, with DONE=1 on that transition cycle (registered, visible the cycle after the last drain step).
    - LENGTH=1: counter loads 0; DRAIN lasts one cycle, then DONE.
- Skew:
  - Lane i of each vector passes through i shift stages plus one output register (total i+1 registers).
  - Registers advance only on a step. With no step they hold, so the array sees no data change while ARR_EN=0.
  - After step n: ARR_INPUTS[i] = IN_INPUTS[i] of frame step n-i; ARR_WEIGHTS[j] likewise. Steps before the frame or after IN_LAST contribute 0.
  - Skew registers are not cleared by START. Residual content is zero after any completed drain.
- ARR_EN: registered copy of step; high exactly the cycle after each step, aligned with the updated ARR_* outputs.
- Stall: IN_VALID=0 in STREAM gives no step; ARR_EN=0 next cycle; outputs hold.
- START outside IDLE is ignored. IN_LAST is ignored when no accept occurs.
- Arithmetic: no data arithmetic. Drain counter width is $clog2(2*LENGTH)+1; it never wraps.

Decomposition:
- Shared package mmu_pkg: state enum type setup_state_t (IDLE, CLEAR, STREAM, DRAIN); function drain_steps(LENGTH)=2*(LENGTH-1).
- One sub-module, skew_lane #(WIDTH, DEPTH): a DEPTH-stage enable-gated shift register with synchronous active-low clear.
  - Instantiated 2*LENGTH times via generate, with DEPTH=i+1.

Test Plan (WIDTH=8, LENGTH=4):
- Reset during STREAM after 2 accepts -> next cycle all ARR_* = 0, ARR_EN=0, IN_READY=0, BUSY=0; no DONE ever.
- START pulse -> ARR_CLR=1 for exactly one cycle, then IN_READY=1; ARR_EN stays 0 until the first accept.
- Four back-to-back accepts, IN_INPUTS={k,k,k,k} for k=1..4, IN_LAST on k=4:
  - ARR_INPUTS per ARR_EN cycle, lanes 0..3: {1,0,0,0} {2,1,0,0} {3,2,1,0} {4,3,2,1}, then drain {0,4,3,2} {0,0,4,3} {0,0,0,4} {0,0,0,0}, then two more cycles of {0,0,0,0}.
  - DONE pulses once, 6 drain steps after the last accept.
- Same frame with IN_VALID low for 3 cycles between k=2 and k=3 -> ARR_EN low for exactly those 3 cycles; outputs hold {2,1,0,0}; subsequent sequence unchanged.
- ARR_WEIGHTS check: IN_WEIGHTS={10,20,30,40} on a single IN_LAST accept -> ARR_WEIGHTS {10,0,0,0} {0,20,0,0} {0,0,30,0} {0,0,0,40} on successive ARR_EN cycles.
- START held high during STREAM/DRAIN -> no re-entry to CLEAR. START asserted the cycle DONE pulses (state IDLE) -> accepted; CLEAR follows the next cycle.

Source files
------------

// File: rtl/mmu_pkg.sv
// Shared types and helpers for the matrix-multiply unit front end.
package mmu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN
    } setup_state_t;

    // Steps needed to push the last real element out of the deepest lane.
    function automatic int drain_steps(input int length);
        return 2 * (length - 1);
    endfunction

endpackage

// File: rtl/skew_lane.sv
// One lane of the diagonal skew: DEPTH-stage shift register advancing only on en.
module skew_lane #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [DEPTH-1:0][WIDTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            sr <= '0;
        end else if (en) begin
            sr[0] <= d;
            for (int k = 1; k < DEPTH; k++) begin
                sr[k] <= sr[k-1];
            end
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/systolic_data_setup.sv
// Feeder for the output-stationary systolic array: skews input/weight vectors,
// sequences clear/enable strobes and drains the pipeline with zeros.
module systolic_data_setup
    import mmu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int LENGTH = 256
) (
    input  logic             CLK,
    input  logic             SYNC_RST,
    input  logic             START,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic             IN_LAST,
    input  logic [WIDTH-1:0] IN_INPUTS   [0:LENGTH-1],
    input  logic [WIDTH-1:0] IN_WEIGHTS  [0:LENGTH-1],
    output logic [WIDTH-1:0] ARR_INPUTS  [0:LENGTH-1],
    output logic [WIDTH-1:0] ARR_WEIGHTS [0:LENGTH-1],
    output logic             ARR_EN,
    output logic             ARR_CLR,
    output logic             BUSY,
    output logic             DONE
);

    localparam int             CW         = $clog2(2 * LENGTH) + 1;
    localparam logic [CW-1:0]  DRAIN_LOAD = CW'(drain_steps(LENGTH));

    setup_state_t  state;
    logic [CW-1:0] drain_cnt;
    logic          streaming;
    logic          accept;
    logic          step;

    assign streaming = (state == STREAM);
    assign accept    = streaming & IN_VALID;
    // A step is either an accepted pair or a zero-fill cycle while draining.
    assign step      = accept | ((state == DRAIN) && (drain_cnt != '0));
    assign IN_READY  = streaming;
    assign BUSY      = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (!SYNC_RST) begin
            state     <= IDLE;
            drain_cnt <= '0;
            ARR_EN    <= 1'b0;
            ARR_CLR   <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            ARR_EN  <= step;
            ARR_CLR <= 1'b0;
            DONE    <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        state   <= CLEAR;
                        ARR_CLR <= 1'b1;
                    end
                end
                CLEAR: begin
                    state <= STREAM;
                end
                STREAM: begin
                    if (accept && IN_LAST) begin
                        state     <= DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                    end
                end
                DRAIN: begin
                    if (drain_cnt != '0) begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end else begin
                        state <= IDLE;
                        DONE  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Lane i is i+1 registers deep; zeros are shifted in outside STREAM.
    for (genvar i = 0; i < LENGTH; i++) begin : g_lane
        logic [WIDTH-1:0] in_d;
        logic [WIDTH-1:0] wt_d;

        assign in_d = streaming ? IN_INPUTS[i]  : '0;
        assign wt_d = streaming ? IN_WEIGHTS[i] : '0;

        skew_lane #(
            .WIDTH (WIDTH),
            .DEPTH (i + 1)
        ) u_in (
            .clk   (CLK),
            .clr_n (SYNC_RST),
            .en    (step),
            .d     (in_d),
            .q     (ARR_INPUTS[i])
        );

        skew_lane #(
            .WIDTH (WIDTH),
            .DEPTH (i + 1)
        ) u_wt (
            .clk   (CLK),
            .clr_n (SYNC_RST),
            .en    (step),
            .d     (wt_d),
            .q     (ARR_WEIGHTS[i])
        );
    end

endmodule

// File: tb/tb_systolic_data_setup.sv
// Scoreboard bench for systolic_data_setup at WIDTH=8, LENGTH=4.
module tb_systolic_data_setup;

    localparam int L = 4;

    typedef enum int {P_IDLE, P_CLEAR, P_STREAM, P_DRAIN} ph_t;
    typedef struct packed {
        logic [31:0] i;
        logic [31:0] w;
    } exp_t;

    logic       clk = 1'b0;
    logic       sync_rst;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic       in_last;
    logic [7:0] in_inputs   [0:L-1];
    logic [7:0] in_weights  [0:L-1];
    logic [7:0] arr_inputs  [0:L-1];
    logic [7:0] arr_weights [0:L-1];
    logic       arr_en;
    logic       arr_clr;
    logic       busy;
    logic       done;

    exp_t        sb[$];
    exp_t        me;
    logic [31:0] log_i[$];
    logic [31:0] log_w[$];
    logic [31:0] hist_i [0:L-1];
    logic [31:0] hist_w [0:L-1];
    int          n_chk = 0;
    int          n_pass = 0;
    ph_t         ph;
    int          dl;
    bit          done_exp;

    systolic_data_setup #(.WIDTH(8), .LENGTH(L)) dut (
        .CLK         (clk),
        .SYNC_RST    (sync_rst),
        .START       (start),
        .IN_VALID    (in_valid),
        .IN_READY    (in_ready),
        .IN_LAST     (in_last),
        .IN_INPUTS   (in_inputs),
        .IN_WEIGHTS  (in_weights),
        .ARR_INPUTS  (arr_inputs),
        .ARR_WEIGHTS (arr_weights),
        .ARR_EN      (arr_en),
        .ARR_CLR     (arr_clr),
        .BUSY        (busy),
        .DONE        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    function automatic logic [31:0] pk(input logic [7:0] v [0:L-1]);
        return {v[3], v[2], v[1], v[0]};
    endfunction

    // hist_x[d] holds the vector of the step d steps ago; lane l sees hist_x[l].
    task automatic model_step(input logic [31:0] vi, input logic [31:0] vw);
        exp_t e;
        for (int d = L - 1; d > 0; d--) begin
            hist_i[d] = hist_i[d-1];
            hist_w[d] = hist_w[d-1];
        end
        hist_i[0] = vi;
        hist_w[0] = vw;
        for (int l = 0; l < L; l++) begin
            e.i[8*l +: 8] = hist_i[l][8*l +: 8];
            e.w[8*l +: 8] = hist_w[l][8*l +: 8];
        end
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (arr_en === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                me = sb.pop_front();
                chk("arr_inputs", pk(arr_inputs), me.i);
                chk("arr_weights", pk(arr_weights), me.w);
            end
            log_i.push_back(pk(arr_inputs));
            log_w.push_back(pk(arr_weights));
        end
    end

    // One clock cycle: called at posedge+1, returns at the next posedge+1.
    task automatic cyc(input bit v, input bit last, input bit st,
                       input logic [31:0] ins = '0, input logic [31:0] wts = '0);
        bit          stp;
        logic [31:0] prev_i;
        start    = st;
        in_valid = v;
        in_last  = last;
        for (int l = 0; l < L; l++) begin
            in_inputs[l]  = ins[8*l +: 8];
            in_weights[l] = wts[8*l +: 8];
        end
        chk("in_ready", {31'd0, in_ready}, {31'd0, ph == P_STREAM});
        chk("busy", {31'd0, busy}, {31'd0, ph != P_IDLE});
        chk("arr_clr", {31'd0, arr_clr}, {31'd0, ph == P_CLEAR});
        chk("done", {31'd0, done}, {31'd0, done_exp});
        done_exp = 1'b0;
        stp      = 1'b0;
        case (ph)
            P_IDLE:  if (st) ph = P_CLEAR;
            P_CLEAR: ph = P_STREAM;
            P_STREAM: begin
                if (v) begin
                    stp = 1'b1;
                    model_step(ins, wts);
                    if (last) begin
                        ph = P_DRAIN;
                        dl = 2 * (L - 1);
                    end
                end
            end
            default: begin
                if (dl > 0) begin
                    stp = 1'b1;
                    model_step('0, '0);
                    dl--;
                end else begin
                    ph       = P_IDLE;
                    done_exp = 1'b1;
                end
            end
        endcase
        prev_i = pk(arr_inputs);
        @(posedge clk);
        #1;
        chk("arr_en", {31'd0, arr_en}, {31'd0, stp});
        if (!stp) chk("hold", pk(arr_inputs), prev_i);
    endtask

    task automatic rst_cycles(input int n);
        sync_rst = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        sync_rst = 1'b1;
        ph       = P_IDLE;
        dl       = 0;
        done_exp = 1'b0;
        for (int d = 0; d < L; d++) begin
            hist_i[d] = '0;
            hist_w[d] = '0;
        end
        chk("rst_in", pk(arr_inputs), 32'd0);
        chk("rst_wt", pk(arr_weights), 32'd0);
        chk("rst_en", {31'd0, arr_en}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_clr", {31'd0, arr_clr}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
    endtask

    task automatic run_frame(input bit stall, input bit st);
        logic [31:0] gold [0:9];
        gold = '{32'h00000001, 32'h00000102, 32'h00010203, 32'h01020304, 32'h02030400,
                 32'h03040000, 32'h04000000, 32'h00000000, 32'h00000000, 32'h00000000};
        cyc(0, 0, 1);
        cyc(0, 0, st);
        log_i.delete();
        log_w.delete();
        cyc(1, 0, st, 32'h01010101, 32'h03030303);
        cyc(1, 0, st, 32'h02020202, 32'h06060606);
        if (stall) repeat (3) cyc(0, 0, st);
        cyc(1, 0, st, 32'h03030303, 32'h09090909);
        cyc(1, 1, st, 32'h04040404, 32'h0c0c0c0c);
        repeat (7) cyc(0, 0, st);
        chk("log_len", 32'(log_i.size()), 32'd10);
        for (int n = 0; n < 10 && n < log_i.size(); n++) chk("seq_in", log_i[n], gold[n]);
    endtask

    initial begin
        logic [31:0] gw [0:3];
        gw = '{32'h0000000a, 32'h00001400, 32'h001e0000, 32'h28000000};
        sync_rst = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int l = 0; l < L; l++) begin
            in_inputs[l]  = '0;
            in_weights[l] = '0;
        end
        rst_cycles(2);

        // Abort mid-frame after two accepts.
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(1, 0, 0, 32'h01010101, 32'h05050505);
        cyc(1, 0, 0, 32'h02020202, 32'h07070707);
        rst_cycles(1);
        repeat (3) cyc(0, 0, 0);

        run_frame(0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);

        run_frame(1, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);

        // Single-accept frame exercising weight skew.
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        log_w.delete();
        log_i.delete();
        cyc(1, 1, 0, 32'h04030201, 32'h281e140a);
        repeat (7) cyc(0, 0, 0);
        chk("wlog_len", 32'(log_w.size()), 32'd7);
        for (int n = 0; n < 4 && n < log_w.size(); n++) chk("seq_wt", log_w[n], gw[n]);
        cyc(0, 0, 0);

        // START held through STREAM/DRAIN; restart on the DONE cycle.
        run_frame(0, 1);
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        cyc(1, 1, 0, 32'h09080706, 32'h01020304);
        repeat (7) cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
